conv_seq_apb: RTL and testbench

- Second-generation APB control block for the convolution core. Replaces the single-shot start/done register file with a parametrised descriptor queue.
- Software stages per-layer configuration (COMMAND, InCh, OutCh, FLength) and pushes it into a FIFO. A sequencer launches layers back-to-back on the conv core without CPU intervention.
- Also owns the filter/bias/transmit handshake flags and a layer-completion counter. Sits between the APB bus and the conv datapath inside the conv top level.

---
 rtl/conv_seq_pkg.sv | 48 ++++
 rtl/conv_seq_apb_if.sv | 23 ++
 rtl/conv_desc_fifo.sv | 57 +++++
 rtl/conv_seq_apb.sv | 206 ++++++++++++++++++++
 tb/tb_conv_seq_apb.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the conv_seq_apb descriptor-queue control block:
// register offsets, CTRL/STATUS/IRQ bit positions, sequencer states, descriptor layout.
package conv_seq_pkg;

  localparam int P_CMD_W  = 3;
  localparam int P_CH_W   = 9;
  localparam int P_FLEN_W = 6;

  localparam int REG_CTRL     = 'h00;
  localparam int REG_CFG_IN   = 'h04;
  localparam int REG_CFG_OUT  = 'h08;
  localparam int REG_CFG_MISC = 'h0C;
  localparam int REG_STATUS   = 'h10;
  localparam int REG_IRQ      = 'h14;
  localparam int REG_IRQ_EN   = 'h18;

  localparam int CTRL_PUSH     = 0;
  localparam int CTRL_SET_F    = 1;
  localparam int CTRL_SET_B    = 2;
  localparam int CTRL_RTR_RESP = 3;
  localparam int CTRL_TD_RESP  = 4;
  localparam int CTRL_FLUSH    = 5;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_RTR   = 3;
  localparam int ST_TD    = 4;

  localparam int IRQ_LAYER = 0;
  localparam int IRQ_DRAIN = 1;
  localparam int IRQ_RTR   = 2;
  localparam int IRQ_W     = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [P_CMD_W-1:0]  cmd;
    logic [P_CH_W-1:0]   inch;
    logic [P_CH_W-1:0]   outch;
    logic [P_FLEN_W-1:0] flen;
  } desc_t;

endpackage

// File: rtl/conv_seq_apb_if.sv
// APB3 slave-side bundle for conv_seq_apb; signal names follow the bus standard.
interface conv_seq_apb_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/conv_desc_fifo.sv
// Synchronous descriptor FIFO with count/full/empty, simultaneous push+pop, and a
// flush that takes effect before a same-cycle push.
module conv_desc_fifo #(
  parameter int QDEPTH = 4,
  parameter int DW     = 27
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  logic [DW-1:0]             i_data,
  output logic [DW-1:0]             o_data,
  output logic [$clog2(QDEPTH):0]   o_count,
  output logic                      o_full,
  output logic                      o_empty
);
  localparam int PW = $clog2(QDEPTH);

  logic [DW-1:0] r_mem [QDEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push, w_do_pop;
  logic [PW-1:0] w_wr_addr;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PW+1)'(QDEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (i_flush | ~o_full | w_do_pop);
  assign w_wr_addr = i_flush ? '0 : r_wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= PW'(w_do_push);
      r_count  <= (PW+1)'(w_do_push);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage is not reset; the count gates every read so stale entries are never observed.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[w_wr_addr] <= i_data;
  end

endmodule

// File: rtl/conv_seq_apb.sv
// APB descriptor-queue sequencer for the conv core: staging regs, FIFO, launch FSM,
// handshake flags and layer counter. Optional IRQ block under `CONV_SEQ_IRQ_EN.
module conv_seq_apb
  import conv_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CMD_W  = P_CMD_W,
  parameter int CH_W   = P_CH_W,
  parameter int FLEN_W = P_FLEN_W,
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  conv_seq_apb_if.slave     apb,
  output logic              conv_start,
  input  logic              conv_done,
  output logic [CMD_W-1:0]  COMMAND,
  output logic [CH_W-1:0]   InCh,
  output logic [CH_W-1:0]   OutCh,
  output logic [FLEN_W-1:0] FLength,
  output logic              F_writedone,
  input  logic              F_writedone_respond,
  output logic              B_writedone,
  input  logic              B_writedone_respond,
  input  logic              rdy_to_transmit,
  output logic              rdy_to_transmit_respond,
  input  logic              transmit_done,
  output logic              transmit_done_respond,
  output logic              irq
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int DW = $bits(desc_t);

  logic [ADDR_W-1:0] w_addr;
  logic w_setup, w_access, w_slverr, w_wr, w_wr_ctrl, w_mapped;
  logic w_hit_ctrl, w_hit_in, w_hit_out, w_hit_misc, w_hit_status, w_hit_irq, w_hit_irq_en;
  logic w_push, w_pop, w_flush, w_full, w_empty, w_busy, w_layer_done;
  logic [CW-1:0] w_count;
  logic [DW-1:0] w_head;
  logic [31:0] w_rdata, w_irq_rd, w_irq_en_rd;
  seq_state_e r_state, w_next;
  desc_t r_stage, r_active;
  logic [CNT_W-1:0] r_layer_cnt;
  logic [31:0] r_prdata;
  logic r_f_done, r_b_done, r_rtr_resp, r_td_resp;

  assign w_addr       = apb.PADDR;
  assign w_setup      = apb.PSEL & ~apb.PENABLE;
  assign w_access     = apb.PSEL & apb.PENABLE;
  assign w_hit_ctrl   = (w_addr == ADDR_W'(REG_CTRL));
  assign w_hit_in     = (w_addr == ADDR_W'(REG_CFG_IN));
  assign w_hit_out    = (w_addr == ADDR_W'(REG_CFG_OUT));
  assign w_hit_misc   = (w_addr == ADDR_W'(REG_CFG_MISC));
  assign w_hit_status = (w_addr == ADDR_W'(REG_STATUS));
  assign w_hit_irq    = (w_addr == ADDR_W'(REG_IRQ));
  assign w_hit_irq_en = (w_addr == ADDR_W'(REG_IRQ_EN));
  assign w_mapped     = w_hit_ctrl | w_hit_in | w_hit_out | w_hit_misc |
                        w_hit_status | w_hit_irq | w_hit_irq_en;

  // A flush in the same write frees space, so only a push without flush can overflow.
  assign w_slverr = w_access & (~w_mapped | (apb.PWRITE & w_hit_status) |
                    (apb.PWRITE & w_hit_ctrl & apb.PWDATA[CTRL_PUSH] &
                     ~apb.PWDATA[CTRL_FLUSH] & w_full));
  assign w_wr      = w_access & apb.PWRITE & ~w_slverr;
  assign w_wr_ctrl = w_wr & w_hit_ctrl;
  assign w_push    = w_wr_ctrl & apb.PWDATA[CTRL_PUSH];
  assign w_flush   = w_wr_ctrl & apb.PWDATA[CTRL_FLUSH];
  assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~w_flush;

  assign apb.PSLVERR = w_slverr;
  assign apb.PREADY  = 1'b1;
  assign apb.PRDATA  = r_prdata;

  conv_desc_fifo #(.QDEPTH(QDEPTH), .DW(DW)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (r_stage),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_pop) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_RUN;
      S_RUN:    if (conv_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    conv_start   = (r_state == S_LAUNCH);
    w_busy       = (r_state != S_IDLE);
    w_layer_done = (r_state == S_RUN) & conv_done;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stage     <= '0;
      r_active    <= '0;
      r_layer_cnt <= '0;
      r_f_done    <= 1'b0;
      r_b_done    <= 1'b0;
      r_rtr_resp  <= 1'b0;
      r_td_resp   <= 1'b0;
      r_prdata    <= '0;
    end else begin
      if (w_wr && w_hit_in)  r_stage.inch  <= apb.PWDATA[CH_W-1:0];
      if (w_wr && w_hit_out) r_stage.outch <= apb.PWDATA[CH_W-1:0];
      if (w_wr && w_hit_misc) begin
        r_stage.cmd  <= apb.PWDATA[CMD_W-1:0];
        r_stage.flen <= apb.PWDATA[FLEN_W+7:8];
      end
      if (w_pop)        r_active    <= desc_t'(w_head);
      if (w_layer_done) r_layer_cnt <= r_layer_cnt + 1'b1;
      // A set in the same cycle as the core's acknowledge wins.
      if (w_wr_ctrl && apb.PWDATA[CTRL_SET_F]) r_f_done <= 1'b1;
      else if (F_writedone_respond)            r_f_done <= 1'b0;
      if (w_wr_ctrl && apb.PWDATA[CTRL_SET_B]) r_b_done <= 1'b1;
      else if (B_writedone_respond)            r_b_done <= 1'b0;
      r_rtr_resp <= w_wr_ctrl & apb.PWDATA[CTRL_RTR_RESP];
      r_td_resp  <= w_wr_ctrl & apb.PWDATA[CTRL_TD_RESP];
      if (w_setup) r_prdata <= w_rdata;
    end
  end

`ifdef CONV_SEQ_IRQ_EN
  logic [IRQ_W-1:0] r_irq, r_irq_en, w_irq_set, w_irq_clr;
  logic             r_rtr_d;

  always_comb begin
    w_irq_set            = '0;
    w_irq_set[IRQ_LAYER] = w_layer_done;
    w_irq_set[IRQ_DRAIN] = w_layer_done & w_empty;
    w_irq_set[IRQ_RTR]   = rdy_to_transmit & ~r_rtr_d;
    w_irq_clr            = (w_wr && w_hit_irq) ? apb.PWDATA[IRQ_W-1:0] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_irq    <= '0;
      r_irq_en <= '0;
      r_rtr_d  <= 1'b0;
    end else begin
      r_rtr_d <= rdy_to_transmit;
      r_irq   <= (r_irq & ~w_irq_clr) | w_irq_set;
      if (w_wr && w_hit_irq_en) r_irq_en <= apb.PWDATA[IRQ_W-1:0];
    end
  end

  assign irq         = |(r_irq & r_irq_en);
  assign w_irq_rd    = 32'(r_irq);
  assign w_irq_en_rd = 32'(r_irq_en);
`else
  assign irq         = 1'b0;
  assign w_irq_rd    = '0;
  assign w_irq_en_rd = '0;
`endif

  always_comb begin
    w_rdata = '0;
    if (w_hit_in) begin
      w_rdata[CH_W-1:0] = r_stage.inch;
    end else if (w_hit_out) begin
      w_rdata[CH_W-1:0] = r_stage.outch;
    end else if (w_hit_misc) begin
      w_rdata[CMD_W-1:0]    = r_stage.cmd;
      w_rdata[FLEN_W+7:8]   = r_stage.flen;
    end else if (w_hit_status) begin
      w_rdata[ST_BUSY]  = w_busy;
      w_rdata[ST_EMPTY] = w_empty;
      w_rdata[ST_FULL]  = w_full;
      w_rdata[ST_RTR]   = rdy_to_transmit;
      w_rdata[ST_TD]    = transmit_done;
      w_rdata[15:8]     = 8'(w_count);
      w_rdata[31:16]    = 16'(r_layer_cnt);
    end else if (w_hit_irq) begin
      w_rdata = w_irq_rd;
    end else if (w_hit_irq_en) begin
      w_rdata = w_irq_en_rd;
    end
  end

  assign COMMAND                 = r_active.cmd;
  assign InCh                    = r_active.inch;
  assign OutCh                   = r_active.outch;
  assign FLength                 = r_active.flen;
  assign F_writedone             = r_f_done;
  assign B_writedone             = r_b_done;
  assign rdy_to_transmit_respond = r_rtr_resp;
  assign transmit_done_respond   = r_td_resp;

endmodule

// File: tb/tb_conv_seq_apb.sv
// Directed bench for conv_seq_apb; IRQ expectations follow `CONV_SEQ_IRQ_EN.
module tb_conv_seq_apb;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  conv_seq_apb_if #(.ADDR_W(16)) apb ();

  logic       conv_start, conv_done;
  logic [2:0] COMMAND;
  logic [8:0] InCh, OutCh;
  logic [5:0] FLength;
  logic       F_writedone, F_writedone_respond, B_writedone, B_writedone_respond;
  logic       rdy_to_transmit, rdy_to_transmit_respond, transmit_done, transmit_done_respond;
  logic       irq;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd;
  logic        err;

  conv_seq_apb dut (
    .CLK                     (CLK),
    .RESET                   (RESET),
    .apb                     (apb),
    .conv_start              (conv_start),
    .conv_done               (conv_done),
    .COMMAND                 (COMMAND),
    .InCh                    (InCh),
    .OutCh                   (OutCh),
    .FLength                 (FLength),
    .F_writedone             (F_writedone),
    .F_writedone_respond     (F_writedone_respond),
    .B_writedone             (B_writedone),
    .B_writedone_respond     (B_writedone_respond),
    .rdy_to_transmit         (rdy_to_transmit),
    .rdy_to_transmit_respond (rdy_to_transmit_respond),
    .transmit_done           (transmit_done),
    .transmit_done_respond   (transmit_done_respond),
    .irq                     (irq)
  );

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic e);
    @(posedge CLK); #1;
    apb.PADDR = a; apb.PWDATA = d; apb.PWRITE = 1'b1; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    @(posedge CLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge CLK);
    e = apb.PSLVERR;
    @(posedge CLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic e);
    @(posedge CLK); #1;
    apb.PADDR = a; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    @(posedge CLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge CLK);
    d = apb.PRDATA;
    e = apb.PSLVERR;
    @(posedge CLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge CLK); #1 conv_done = 1'b1;
    @(posedge CLK); #1 conv_done = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checks++; if (apb.PREADY !== 1'b1) begin failures++; $display("FAIL reset_pready: got %b exp 1", apb.PREADY); end
    checks++; if ({conv_start, F_writedone, B_writedone, rdy_to_transmit_respond, transmit_done_respond, irq, apb.PSLVERR} !== 7'b0)
      begin failures++; $display("FAIL reset_ctl_outs: got %b exp 0", {conv_start, F_writedone, B_writedone, rdy_to_transmit_respond, transmit_done_respond, irq, apb.PSLVERR}); end
    checks++; if ({COMMAND, InCh, OutCh, FLength} !== 27'b0 || apb.PRDATA !== 32'h0)
      begin failures++; $display("FAIL reset_data_outs: got %h/%h exp 0/0", {COMMAND, InCh, OutCh, FLength}, apb.PRDATA); end
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0000_0002 || err !== 1'b0) begin failures++; $display("FAIL reset_status: got %h err %b exp 00000002 err 0", rd, err); end
  endtask

  task automatic test_single_layer();
    apb_write(16'h18, 32'h1, err);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL irq_en_wr_err: got %b exp 0", err); end
    apb_write(16'h04, 32'd3, err);
    apb_write(16'h08, 32'd16, err);
    apb_write(16'h0C, 32'h0000_2001, err);
    apb_write(16'h00, 32'h1, err);
    @(negedge CLK);
    checks++; if (conv_start !== 1'b0) begin failures++; $display("FAIL launch_early: got %b exp 0", conv_start); end
    @(negedge CLK);
    checks++; if (conv_start !== 1'b1) begin failures++; $display("FAIL launch_pulse: got %b exp 1", conv_start); end
    checks++; if ({COMMAND, InCh, OutCh, FLength} !== {3'd1, 9'd3, 9'd16, 6'd32})
      begin failures++; $display("FAIL launch_desc: got %h exp %h", {COMMAND, InCh, OutCh, FLength}, {3'd1, 9'd3, 9'd16, 6'd32}); end
    @(negedge CLK);
    checks++; if (conv_start !== 1'b0) begin failures++; $display("FAIL launch_one_cycle: got %b exp 0", conv_start); end
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0000_0003) begin failures++; $display("FAIL status_run: got %h exp 00000003", rd); end
    pulse_done();
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0001_0002) begin failures++; $display("FAIL status_done1: got %h exp 00010002", rd); end
    apb_read(16'h14, rd, err);
`ifdef CONV_SEQ_IRQ_EN
    checks++; if (rd !== 32'h3 || irq !== 1'b1) begin failures++; $display("FAIL irq_layer: got %h irq %b exp 3 irq 1", rd, irq); end
`else
    checks++; if (rd !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL irq_off_layer: got %h irq %b exp 0 irq 0", rd, irq); end
`endif
    apb_write(16'h14, 32'h3, err);
    @(negedge CLK);
    checks++; if (irq !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL irq_w1c: got irq %b err %b exp 0 0", irq, err); end
  endtask

  task automatic test_queue_full();
    for (int i = 1; i <= 5; i++) begin
      apb_write(16'h04, 32'(i), err);
      apb_write(16'h00, 32'h1, err);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL push_err_%0d: got %b exp 0", i, err); end
    end
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0001_0405) begin failures++; $display("FAIL status_full: got %h exp 00010405", rd); end
    apb_write(16'h04, 32'd99, err);
    apb_write(16'h00, 32'h1, err);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL overflow_slverr: got %b exp 1", err); end
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0001_0405) begin failures++; $display("FAIL status_after_overflow: got %h exp 00010405", rd); end
    checks++; if (InCh !== 9'd1) begin failures++; $display("FAIL inflight_first: got %0d exp 1", InCh); end
    for (int i = 2; i <= 5; i++) begin
      pulse_done();
      @(negedge CLK);
      checks++; if (conv_start !== 1'b0) begin failures++; $display("FAIL gap_%0d: got %b exp 0", i, conv_start); end
      @(negedge CLK);
      checks++; if (conv_start !== 1'b1 || InCh !== 9'(i))
        begin failures++; $display("FAIL order_%0d: got start %b inch %0d exp 1 %0d", i, conv_start, InCh, i); end
    end
    pulse_done();
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0006_0002) begin failures++; $display("FAIL status_drained: got %h exp 00060002", rd); end
    apb_read(16'h14, rd, err);
`ifdef CONV_SEQ_IRQ_EN
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL irq_drain: got %h exp 3", rd); end
`else
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL irq_off_drain: got %h exp 0", rd); end
`endif
    apb_write(16'h14, 32'h7, err);
  endtask

  task automatic test_flags();
    apb_write(16'h00, 32'h2, err);
    @(negedge CLK);
    checks++; if (F_writedone !== 1'b1) begin failures++; $display("FAIL f_set: got %b exp 1", F_writedone); end
    @(posedge CLK); #1;
    apb.PADDR = 16'h00; apb.PWDATA = 32'h2; apb.PWRITE = 1'b1; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    @(posedge CLK); #1;
    apb.PENABLE = 1'b1; F_writedone_respond = 1'b1;
    @(posedge CLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; F_writedone_respond = 1'b0;
    @(negedge CLK);
    checks++; if (F_writedone !== 1'b1) begin failures++; $display("FAIL f_set_wins: got %b exp 1", F_writedone); end
    @(posedge CLK); #1 F_writedone_respond = 1'b1;
    @(negedge CLK);
    checks++; if (F_writedone !== 1'b1) begin failures++; $display("FAIL f_hold_during_resp: got %b exp 1", F_writedone); end
    @(posedge CLK); #1 F_writedone_respond = 1'b0;
    @(negedge CLK);
    checks++; if (F_writedone !== 1'b0) begin failures++; $display("FAIL f_clear: got %b exp 0", F_writedone); end
    apb_write(16'h00, 32'h4, err);
    @(negedge CLK);
    checks++; if ({F_writedone, B_writedone} !== 2'b01) begin failures++; $display("FAIL b_set: got %b exp 01", {F_writedone, B_writedone}); end
    @(posedge CLK); #1 B_writedone_respond = 1'b1;
    @(posedge CLK); #1 B_writedone_respond = 1'b0;
    @(negedge CLK);
    checks++; if (B_writedone !== 1'b0) begin failures++; $display("FAIL b_clear: got %b exp 0", B_writedone); end
  endtask

  task automatic test_transmit();
    apb_write(16'h18, 32'h4, err);
    @(posedge CLK); #1 rdy_to_transmit = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
`ifdef CONV_SEQ_IRQ_EN
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rtr_edge: got %b exp 1", irq); end
`else
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_off_rtr: got %b exp 0", irq); end
`endif
    apb_write(16'h14, 32'h4, err);
    @(negedge CLK);
    checks++; if (irq !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL irq_rtr_w1c: got irq %b err %b exp 0 0", irq, err); end
    apb_write(16'h00, 32'h8, err);
    @(negedge CLK);
    checks++; if ({rdy_to_transmit_respond, transmit_done_respond} !== 2'b10)
      begin failures++; $display("FAIL rtr_resp_pulse: got %b exp 10", {rdy_to_transmit_respond, transmit_done_respond}); end
    @(negedge CLK);
    checks++; if (rdy_to_transmit_respond !== 1'b0) begin failures++; $display("FAIL rtr_resp_one_cycle: got %b exp 0", rdy_to_transmit_respond); end
    apb_write(16'h00, 32'h10, err);
    @(negedge CLK);
    checks++; if ({rdy_to_transmit_respond, transmit_done_respond} !== 2'b01)
      begin failures++; $display("FAIL td_resp_pulse: got %b exp 01", {rdy_to_transmit_respond, transmit_done_respond}); end
    @(negedge CLK);
    checks++; if (transmit_done_respond !== 1'b0) begin failures++; $display("FAIL td_resp_one_cycle: got %b exp 0", transmit_done_respond); end
    transmit_done = 1'b1;
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0006_001A) begin failures++; $display("FAIL status_core_flags: got %h exp 0006001a", rd); end
    rdy_to_transmit = 1'b0;
    transmit_done = 1'b0;
  endtask

  task automatic test_errors();
    apb_write(16'h10, 32'hFFFF_FFFF, err);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ro_write_slverr: got %b exp 1", err); end
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0006_0002 || err !== 1'b0) begin failures++; $display("FAIL ro_unchanged: got %h err %b exp 00060002 err 0", rd, err); end
    apb_read(16'h1C, rd, err);
    checks++; if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL unmapped_read: got %h err %b exp 0 err 1", rd, err); end
    apb_write(16'h06, 32'h1, err);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL misaligned_write: got %b exp 1", err); end
    apb_write(16'h04, 32'hFFFF_FFFF, err);
    apb_read(16'h04, rd, err);
    checks++; if (rd !== 32'h0000_01FF) begin failures++; $display("FAIL cfg_in_mask: got %h exp 000001ff", rd); end
    apb_write(16'h0C, 32'hFFFF_FFFF, err);
    apb_read(16'h0C, rd, err);
    checks++; if (rd !== 32'h0000_3F07) begin failures++; $display("FAIL cfg_misc_mask: got %h exp 00003f07", rd); end
    apb_write(16'h18, 32'h7, err);
    apb_read(16'h18, rd, err);
`ifdef CONV_SEQ_IRQ_EN
    checks++; if (rd !== 32'h7 || err !== 1'b0) begin failures++; $display("FAIL irq_en_rw: got %h err %b exp 7 err 0", rd, err); end
    apb_write(16'h18, 32'h0, err);
`else
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL irq_en_off: got %h err %b exp 0 err 0", rd, err); end
`endif
  endtask

  task automatic test_flush();
    for (int i = 10; i <= 12; i++) begin
      apb_write(16'h04, 32'(i), err);
      apb_write(16'h00, 32'h1, err);
    end
    apb_write(16'h00, 32'h20, err);
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0006_0003) begin failures++; $display("FAIL flush_empty: got %h exp 00060003", rd); end
    apb_write(16'h04, 32'd13, err);
    apb_write(16'h00, 32'h1, err);
    apb_write(16'h00, 32'h1, err);
    apb_write(16'h04, 32'd20, err);
    apb_write(16'h00, 32'h21, err);
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0006_0101 || err !== 1'b0) begin failures++; $display("FAIL flush_push: got %h err %b exp 00060101 err 0", rd, err); end
    checks++; if (InCh !== 9'd10) begin failures++; $display("FAIL flush_inflight: got %0d exp 10", InCh); end
    pulse_done();
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (conv_start !== 1'b1 || InCh !== 9'd20) begin failures++; $display("FAIL flush_next: got start %b inch %0d exp 1 20", conv_start, InCh); end
    pulse_done();
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0008_0002) begin failures++; $display("FAIL flush_count: got %h exp 00080002", rd); end
  endtask

  task automatic test_reset_in_run();
    apb_write(16'h00, 32'h2, err);
    apb_write(16'h04, 32'd5, err);
    apb_write(16'h00, 32'h1, err);
    apb_write(16'h04, 32'd6, err);
    apb_write(16'h00, 32'h1, err);
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    checks++; if ({conv_start, F_writedone} !== 2'b00 || InCh !== 9'd0)
      begin failures++; $display("FAIL run_reset_outs: got %b inch %0d exp 00 0", {conv_start, F_writedone}, InCh); end
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0000_0002) begin failures++; $display("FAIL run_reset_status: got %h exp 00000002", rd); end
    pulse_done();
    apb_read(16'h10, rd, err);
    checks++; if (rd !== 32'h0000_0002) begin failures++; $display("FAIL idle_done_ignored: got %h exp 00000002", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apb.PADDR = '0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PWDATA = '0;
    conv_done = 1'b0; F_writedone_respond = 1'b0; B_writedone_respond = 1'b0;
    rdy_to_transmit = 1'b0; transmit_done = 1'b0; RESET = 1'b1;
    test_reset();
    test_single_layer();
    test_queue_full();
    test_flags();
    test_transmit();
    test_errors();
    test_flush();
    test_reset_in_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
